// File: rtl/mux_serializer4_pkg.sv
// Shared definitions for the 4-bit parallel-to-serial stage: FSM encoding and
// the select start/end positions for each shift direction.
package mux_serializer4_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [1:0] start_idx(input bit msb_first);
        return msb_first ? 2'd3 : 2'd0;
    endfunction

    function automatic logic [1:0] end_idx(input bit msb_first);
        return msb_first ? 2'd0 : 2'd3;
    endfunction

endpackage

// File: rtl/mux_serializer4_mux4_1.sv
// 4:1 bit-select mux driven by the serializer's shadow word and select register.
module mux4_1 (
    input  logic [3:0] data,
    input  logic [1:0] sel,
    output logic       y
);

    always_comb begin
        y = data[sel];
    end

endmodule

// File: rtl/mux_serializer4.sv
// Parallel-to-serial stage: latches a 4-bit word on valid/ready, then walks the
// bit-select mux through all four positions, holding each bit DIV clocks.
module mux_serializer4
    import mux_serializer4_pkg::*;
#(
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] data_in,
    input  logic       load_valid_in,
    output logic       load_ready_out,
    input  logic       flush_in,
    output logic       serial_out,
    output logic       serial_valid_out,
    output logic       last_bit_out,
    output logic [1:0] sel_out
);

    localparam int               CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DIV - 1);
    localparam logic [1:0]       START_SEL = start_idx(MSB_FIRST);
    localparam logic [1:0]       END_SEL   = end_idx(MSB_FIRST);

    state_t           state_q, state_d;
    logic [3:0]       shadow_q;
    logic [1:0]       sel_q;
    logic [1:0]       next_sel;
    logic [CNT_W-1:0] cnt_q;
    logic             in_shift;
    logic             bit_done;
    logic             last_bit;
    logic             accept;
    logic             mux_bit;

    assign in_shift = (state_q == SHIFT);
    assign bit_done = (cnt_q == CNT_MAX);
    assign last_bit = in_shift & (sel_q == END_SEL) & bit_done;
    assign accept   = load_valid_in & load_ready_out;
    assign next_sel = MSB_FIRST ? (sel_q - 2'd1) : (sel_q + 2'd1);
    assign sel_out  = sel_q;

    mux4_1 u_mux (
        .data (shadow_q),
        .sel  (sel_q),
        .y    (mux_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A load in the last-bit cycle keeps SHIFT so consecutive words stream without a bubble.
    always_comb begin
        state_d = state_q;
        if (flush_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_d = SHIFT;
                SHIFT:   if (last_bit && !accept) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        load_ready_out   = rst_n & ~flush_in & (~in_shift | last_bit);
        serial_valid_out = in_shift;
        serial_out       = in_shift & mux_bit;
        last_bit_out     = last_bit;
    end

    // Flush keeps the shadow word; it simply stops being driven once IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= 4'd0;
            sel_q    <= START_SEL;
            cnt_q    <= '0;
        end else if (flush_in) begin
            sel_q    <= START_SEL;
            cnt_q    <= '0;
        end else if (accept) begin
            shadow_q <= data_in;
            sel_q    <= START_SEL;
            cnt_q    <= '0;
        end else if (in_shift) begin
            if (bit_done) begin
                cnt_q <= '0;
                sel_q <= last_bit ? START_SEL : next_sel;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mux_serializer4.sv
// Bench for mux_serializer4: four configurations share one stimulus stream; directed
// tables cover the key sequences and a word-level model checks every cycle.
module tb_mux_serializer4;

    localparam int DIVS[4] = '{1, 3, 1, 2};
    localparam bit MSBS[4] = '{1'b0, 1'b0, 1'b1, 1'b0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] din;
    logic       lv;
    logic       fl;
    logic       ser  [4];
    logic       vld  [4];
    logic       lst  [4];
    logic       rdy  [4];
    logic [1:0] selv [4];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mux_serializer4 #(.DIV(1), .MSB_FIRST(1'b0)) u_a (
        .clk(clk), .rst_n(rst_n), .data_in(din), .load_valid_in(lv), .load_ready_out(rdy[0]),
        .flush_in(fl), .serial_out(ser[0]), .serial_valid_out(vld[0]), .last_bit_out(lst[0]),
        .sel_out(selv[0]));
    mux_serializer4 #(.DIV(3), .MSB_FIRST(1'b0)) u_b (
        .clk(clk), .rst_n(rst_n), .data_in(din), .load_valid_in(lv), .load_ready_out(rdy[1]),
        .flush_in(fl), .serial_out(ser[1]), .serial_valid_out(vld[1]), .last_bit_out(lst[1]),
        .sel_out(selv[1]));
    mux_serializer4 #(.DIV(1), .MSB_FIRST(1'b1)) u_c (
        .clk(clk), .rst_n(rst_n), .data_in(din), .load_valid_in(lv), .load_ready_out(rdy[2]),
        .flush_in(fl), .serial_out(ser[2]), .serial_valid_out(vld[2]), .last_bit_out(lst[2]),
        .sel_out(selv[2]));
    mux_serializer4 #(.DIV(2), .MSB_FIRST(1'b0)) u_d (
        .clk(clk), .rst_n(rst_n), .data_in(din), .load_valid_in(lv), .load_ready_out(rdy[3]),
        .flush_in(fl), .serial_out(ser[3]), .serial_valid_out(vld[3]), .last_bit_out(lst[3]),
        .sel_out(selv[3]));

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Word-level model: a word occupies 4*DIV cycles; elapsed cycle count picks the bit.
    bit         m_busy [4] = '{default: 1'b0};
    logic [3:0] m_word [4] = '{default: 4'd0};
    int         m_el   [4] = '{default: 0};

    function automatic int m_idx(int i);
        int k;
        k = m_el[i] / DIVS[i];
        return MSBS[i] ? 3 - k : k;
    endfunction

    function automatic bit m_last(int i);
        return m_busy[i] && (m_el[i] == 4 * DIVS[i] - 1);
    endfunction

    function automatic bit m_rdy(int i);
        return rst_n && !fl && (!m_busy[i] || m_last(i));
    endfunction

    function automatic bit m_ser(int i);
        return m_busy[i] ? m_word[i][m_idx(i)] : 1'b0;
    endfunction

    function automatic logic [1:0] m_sel(int i);
        return m_busy[i] ? 2'(m_idx(i)) : (MSBS[i] ? 2'd3 : 2'd0);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 4; i++) begin
            if (!rst_n) begin
                m_busy[i] <= 1'b0;
                m_el[i]   <= 0;
            end else if (fl) begin
                m_busy[i] <= 1'b0;
            end else if (lv && m_rdy(i)) begin
                m_busy[i] <= 1'b1;
                m_word[i] <= din;
                m_el[i]   <= 0;
            end else if (m_busy[i]) begin
                if (m_last(i)) m_busy[i] <= 1'b0;
                else           m_el[i]   <= m_el[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            check($sformatf("model%0d_ser", i),  8'(ser[i]),  8'(m_ser(i)));
            check($sformatf("model%0d_vld", i),  8'(vld[i]),  8'(m_busy[i]));
            check($sformatf("model%0d_last", i), 8'(lst[i]),  8'(m_last(i)));
            check($sformatf("model%0d_rdy", i),  8'(rdy[i]),  8'(m_rdy(i)));
            check($sformatf("model%0d_sel", i),  8'(selv[i]), 8'(m_sel(i)));
        end
    end

    typedef struct {
        bit         chk;
        int         inst;
        bit         lv;
        logic [3:0] d;
        bit         fl;
        bit         e_ser;
        bit         e_vld;
        bit         e_last;
        bit         e_rdy;
        logic [1:0] e_sel;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(bit chk, int inst, bit lv_, logic [3:0] d_, bit fl_,
                                bit es, bit ev, bit el, bit er, logic [1:0] esel);
        vec_t v;
        v.chk = chk; v.inst = inst; v.lv = lv_; v.d = d_; v.fl = fl_;
        v.e_ser = es; v.e_vld = ev; v.e_last = el; v.e_rdy = er; v.e_sel = esel;
        tbl.push_back(v);
    endfunction

    function automatic void gap(int n);
        for (int i = 0; i < n; i++) add(1'b0, 0, 1'b0, 4'd0, 1'b0, 0, 0, 0, 0, 2'd0);
    endfunction

    logic [3:0] w;
    logic [3:0] w2;

    initial begin
        rst_n = 1'b0; lv = 1'b0; din = 4'd0; fl = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            check("reset_ser", 8'(ser[i]), 8'd0);
            check("reset_vld", 8'(vld[i]), 8'd0);
            check("reset_last", 8'(lst[i]), 8'd0);
            check("reset_rdy", 8'(rdy[i]), 8'd0);
            check("reset_sel", 8'(selv[i]), MSBS[i] ? 8'd3 : 8'd0);
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1 check("release_rdy", 8'(rdy[0]), 8'd1);

        // First word, DIV=1 LSB first
        w = 4'b1011;
        add(1, 0, 1, w, 0, 0, 0, 0, 1, 2'd0);
        for (int k = 0; k < 4; k++) add(1, 0, 0, 4'd0, 0, w[k], 1, k == 3, k == 3, 2'(k));
        add(1, 0, 0, 4'd0, 0, 0, 0, 0, 1, 2'd0);
        gap(20);
        // Bit hold, DIV=3
        w = 4'b0110;
        add(1, 1, 1, w, 0, 0, 0, 0, 1, 2'd0);
        for (int k = 0; k < 12; k++) add(1, 1, 0, 4'd0, 0, w[k/3], 1, k == 11, k == 11, 2'(k/3));
        add(1, 1, 0, 4'd0, 0, 0, 0, 0, 1, 2'd0);
        gap(20);
        // Back-to-back with valid held high, DIV=1
        w = 4'hA; w2 = 4'h5;
        add(1, 0, 1, w, 0, 0, 0, 0, 1, 2'd0);
        for (int k = 0; k < 4; k++) add(1, 0, 1, w2, 0, w[k], 1, k == 3, k == 3, 2'(k));
        for (int k = 0; k < 4; k++) add(1, 0, 0, 4'd0, 0, w2[k], 1, k == 3, k == 3, 2'(k));
        add(1, 0, 0, 4'd0, 0, 0, 0, 0, 1, 2'd0);
        gap(20);
        // MSB first
        w = 4'b1000;
        add(1, 2, 1, w, 0, 0, 0, 0, 1, 2'd3);
        for (int k = 0; k < 4; k++) add(1, 2, 0, 4'd0, 0, w[3-k], 1, k == 3, k == 3, 2'(3 - k));
        add(1, 2, 0, 4'd0, 0, 0, 0, 0, 1, 2'd3);
        gap(20);
        // Flush together with a load during bit 2, DIV=2
        w = 4'b0100;
        add(1, 3, 1, w, 0, 0, 0, 0, 1, 2'd0);
        for (int k = 0; k < 4; k++) add(1, 3, 0, 4'd0, 0, w[k/2], 1, 0, 0, 2'(k/2));
        add(1, 3, 1, 4'hF, 1, 1, 1, 0, 0, 2'd2);
        add(1, 3, 0, 4'd0, 0, 0, 0, 0, 1, 2'd0);
        add(1, 3, 1, 4'b0001, 0, 0, 0, 0, 1, 2'd0);
        add(1, 3, 0, 4'd0, 0, 1, 1, 0, 0, 2'd0);
        add(1, 3, 0, 4'd0, 0, 1, 1, 0, 0, 2'd0);
        add(1, 3, 0, 4'd0, 0, 0, 1, 0, 0, 2'd1);
        gap(20);

        @(posedge clk); #2;
        for (int i = 0; i < tbl.size(); i++) begin
            lv = tbl[i].lv; din = tbl[i].d; fl = tbl[i].fl;
            @(negedge clk);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_ser", i),  8'(ser[tbl[i].inst]),  8'(tbl[i].e_ser));
                check($sformatf("vec%0d_vld", i),  8'(vld[tbl[i].inst]),  8'(tbl[i].e_vld));
                check($sformatf("vec%0d_last", i), 8'(lst[tbl[i].inst]),  8'(tbl[i].e_last));
                check($sformatf("vec%0d_rdy", i),  8'(rdy[tbl[i].inst]),  8'(tbl[i].e_rdy));
                check($sformatf("vec%0d_sel", i),  8'(selv[tbl[i].inst]), 8'(tbl[i].e_sel));
            end
            @(posedge clk); #2;
        end

        // Asynchronous reset in the middle of a word
        lv = 1'b1; din = 4'hF;
        @(posedge clk); #2;
        lv = 1'b0;
        @(posedge clk); #2;
        check("midword_vld_before", 8'(vld[0]), 8'd1);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("async_ser", 8'(ser[i]), 8'd0);
            check("async_vld", 8'(vld[i]), 8'd0);
            check("async_last", 8'(lst[i]), 8'd0);
            check("async_rdy", 8'(rdy[i]), 8'd0);
            check("async_sel", 8'(selv[i]), MSBS[i] ? 8'd3 : 8'd0);
        end
        @(posedge clk); #2;
        @(posedge clk); #2;
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("after_rst_rdy", 8'(rdy[i]), 8'd1);
            check("after_rst_vld", 8'(vld[i]), 8'd0);
        end

        // Randomized traffic, checked each cycle by the model
        repeat (600) begin
            @(posedge clk); #2;
            lv  = ($urandom_range(0, 3) != 0);
            din = 4'($urandom);
            fl  = ($urandom_range(0, 15) == 0);
        end
        @(posedge clk); #2;
        lv = 1'b0; fl = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_serializer4.md
Name: mux_serializer4

Overview:
Sequential parallel-to-serial stage placed directly upstream of the 4:1 bit-select mux, which it drives. It accepts a 4-bit word over a valid/ready handshake, holds it in a shadow register, and steps the mux select through all four bit positions. Each bit is held for a programmable number of clocks. The result is a framed serial bit stream with valid and last-bit markers for the downstream serial consumer.

Parameters:
DIV, 1, clock cycles each bit is held on serial_out (legal range 1..255; 0 illegal)
MSB_FIRST, 0, 0 = shift bit 0 first (sel 0→3); 1 = shift bit 3 first (sel 3→0)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
data_in  input  4  parallel word to serialize
load_valid_in  input  1  data_in valid
load_ready_out  output  1  block can accept a word this cycle
flush_in  input  1  synchronous abort of current word
serial_out  output  1  current serial bit (bit-select mux output)
serial_valid_out  output  1  serial_out carries a valid bit
last_bit_out  output  1  final cycle of final bit of current word
sel_out  output  2  current bit-select index (observability)

Behaviour:
- Reset and clocking: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset (rst_n low, asynchronous):
  - state = IDLE; shadow word = 0; sel = 0 (3 if MSB_FIRST); bit-hold counter = 0.
  - All outputs 0, including load_ready_out.
- Reset release: load_ready_out rises combinationally from state IDLE. A word may be accepted on the first rising edge after release.
- States:
  - IDLE: load_ready_out = 1; serial_valid_out = 0; serial_out = 0.
  - SHIFT: serial_valid_out = 1; serial_out = shadow[sel].
- Accept: load_valid_in & load_ready_out at a rising edge does the following.
  - Latches data_in into the shadow register.
  - Sets sel to the start index and clears the hold counter.
  - Enters SHIFT.
- Latency: the first bit is on serial_out in the cycle after acceptance. Word duration is exactly 4*DIV cycles of serial_valid_out.
- Hold counter:
  - Counts 0..DIV-1 within each bit.
  - At DIV-1 it wraps to 0 and sel advances: +1, or -1 when MSB_FIRST.
  - The counter is at least 1 bit wide, sized by clog2(DIV).
- last_bit_out = SHIFT & (sel == end index) & (counter == DIV-1). This is combinational from registers.
- load_ready_out = IDLE | last_bit_out. Words can therefore stream back-to-back with no bubble.
- Load during last_bit_out: the new word is latched and the state stays in SHIFT. The next cycle shows bit 0 (or bit 3) of the new word, and serial_valid_out stays high.
- End of word without a load: at last_bit_out with load_valid_in low, the state goes to IDLE and serial_valid_out drops the next cycle.
- data_in / load_valid_in during SHIFT, except in the last_bit_out cycle: ignored, because ready is low. The shadow register is unaffected.
- flush_in:
  - Highest priority. At the edge it forces IDLE, sel to the start index and counter to 0.
  - The shadow word is retained but no longer driven; serial_valid_out is 0 the next cycle.
  - A simultaneous load is NOT accepted: load_ready_out is gated low when flush_in = 1.
  - flush_in in IDLE has no effect beyond the gating above.
- Reset mid-word: the word is abandoned immediately (asynchronous) and nothing is resumed after release.
- The select never leaves 0..3. There is no wrap past the end index, because the state leaves SHIFT or reloads at the end index.

Decomposition:
- Shared package: state encoding (IDLE=0, SHIFT=1) and the start/end index constants derived from MSB_FIRST.
- One sub-module: instantiate the existing 4:1 bit-select mux, mux4_1. Connect the shadow word to its data input, the sel register to its select input, and its output gated with SHIFT to serial_out.
- Counter and FSM live in the top level.

Test Plan:
- Reset/first word: DIV=1, MSB_FIRST=0; hold rst_n low, then check all outputs 0. Release, then load 4'b1011.
  - Required: serial_out = 1,1,0,1 on cycles 1–4 with serial_valid_out high.
  - Required: last_bit_out on cycle 4; IDLE on cycle 5.
- Bit hold: DIV=3, load 4'b0110.
  - Required: serial_out = 0,0,0,1,1,1,1,1,1,0,0,0 over 12 cycles.
  - Required: sel_out steps 0,1,2,3 every 3 cycles; ready low except the final cycle.
- Back-to-back: DIV=1, load_valid_in held high with 4'hA then 4'h5.
  - Required: serial_valid_out continuously high for 8 cycles; stream 0,1,0,1,1,0,1,0.
  - Required: second word accepted in the last_bit_out cycle of the first.
- MSB first: MSB_FIRST=1, load 4'b1000.
  - Required: serial_out = 1,0,0,0; sel_out 3,2,1,0.
- Flush with simultaneous load: DIV=2, flush_in asserted during bit 2 together with load_valid_in.
  - Required: serial_valid_out 0 next cycle; no word accepted.
  - Required: a following load restarts at bit 0.
- Async reset mid-word: drop rst_n between edges during bit 1.
  - Required: outputs 0 immediately, without waiting for a clock edge.
  - Required: after release, the block is in IDLE with load_ready_out = 1.
